uart_tx_cfg: RTL
================

// Module: uart_tx_cfg
// PURPOSE
//   Parametrised, runtime-configurable UART transmitter; successor to the fixed 8-bit/1-stop transmitter.
//   Serialises one frame per valid/ready handshake: start, 5..DBIT_MAX data bits LSB-first, optional parity, 1 or 2 stops.
//   Sits between the TX FIFO/host register block and the pad; bit timing comes from the shared baud generator (s_tick).
// PARAMETERS
//   DBIT_MAX  8    widest data field supported (5..9)
//   OS        16   s_tick pulses per bit (oversampling ratio, >=2)
//   BRK_BITS  13   minimum break length in bit times (UART_TX_BREAK_EN only)
// PORTS
//   clk          in   1                      system clock
//   rst          in   1                      synchronous, active-high reset
//   s_tick       in   1                      one-clk baud-generator pulse, OS per bit
//   tx_valid     in   1                      frame request
//   tx_ready     out  1                      high only in IDLE; transfer when tx_valid&&tx_ready at posedge clk
//   tx_data      in   DBIT_MAX               payload; bits above cfg_dbits ignored
//   cfg_dbits    in   $clog2(DBIT_MAX+1)     data bit count; values outside 5..DBIT_MAX treated as DBIT_MAX
//   cfg_parity   in   2                      00 none, 01 even, 10 odd, 11 treated as none
//   cfg_stop2    in   1                      0 = 1 stop bit, 1 = 2 stop bits
//   tx           out  1                      serial line, registered, idles high
//   tx_busy      out  1                      high in every state except IDLE
//   tx_done_tick out  1                      one-clk pulse at end of last stop bit
// BEHAVIOUR
//   Reset: state IDLE, tx=1, tx_busy=0, tx_done_tick=0, tx_ready=1 from first cycle after rst deasserts.
//   Handshake edge latches tx_data (masked to cfg_dbits), cfg_dbits, cfg_parity, cfg_stop2; config changes mid-frame have no effect.
//   FSM IDLE->START->DATA->[PARITY]->STOP->IDLE; tick counter s (0..OS-1), bit counter n, stop counter.
//   tx is low the cycle after the handshake edge (1 clk latency); each bit lasts exactly OS s_tick pulses.
//   s_tick coincident with the handshake is not counted; counting starts on the next s_tick.
//   DATA: tx=shift[0]; at s==OS-1 on s_tick, shift right; after bit cfg_dbits-1 go PARITY (parity on) else STOP.
//   PARITY: even -> tx = ^data; odd -> tx = ~^data; computed over latched masked data only.
//   STOP: tx=1 for OS (cfg_stop2=0) or 2*OS (cfg_stop2=1) ticks; on last tick tx_done_tick=1 same cycle as return to IDLE.
//   Back-to-back: tx_ready high the cycle after tx_done_tick; a held tx_valid starts the next frame then, tx stays 1 in between.
//   s_tick never asserted: FSM holds state and tx level indefinitely.
//   rst mid-frame: next edge IDLE, tx=1, frame abandoned, no tx_done_tick.
// CONFIGURATION
//   UART_TX_BREAK_EN defined: adds input brk_req (1) and output brk_active (1) and state BREAK.
//     brk_req sampled in IDLE only, priority over tx_valid; tx=0, tx_ready=0, brk_active=1;
//     BREAK held for >= BRK_BITS*OS ticks and until brk_req low; exit to IDLE with tx=1, no tx_done_tick.
//   UART_TX_BREAK_EN undefined: no brk ports, no BREAK state; behaviour as above.
// STRUCTURE
//   uart_pkg: state enum (IDLE,START,DATA,PARITY,STOP,BREAK), parity-mode localparams PAR_NONE/EVEN/ODD,
//     function clamping cfg_dbits.
//   Sub-module uart_bit_timer: s_tick counter with clear, tc output at s==OS-1 && s_tick; reused by RX successor.
// TESTING
//   8N1, 0x55, OS=16: tx = 0,1,0,1,0,1,0,1,0,1 each 16 ticks; tx_done_tick once after 160 ticks.
//   7E2, 0x35 (four ones): parity bit 0, two 16-tick stop bits; total 176 ticks; bit 7 of tx_data ignored.
//   8O1, 0x00: parity bit 1; 5N1 with tx_data=0xFF: only 5 ones sent, 112-tick frame.
//   tx_valid held, data 0xA5 then 0x3C: two frames, tx_ready low throughout each, 1 clk idle between.
//   rst pulsed during DATA bit 3: tx=1 next cycle, tx_ready=1, no tx_done_tick; new frame sends correctly.
//   UART_TX_BREAK_EN, brk_req 1 clk in IDLE: tx low exactly 208 ticks, brk_active high, then IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types: FSM states, parity modes and data-width clamping.
// Used by uart_tx_cfg and uart_bit_timer.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    function automatic int unsigned clamp_dbits(
        input int unsigned dbits,
        input int unsigned dbit_max
    );
        if (dbits < 5 || dbits > dbit_max) begin
            return dbit_max;
        end
        return dbits;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Oversampling tick counter; tc marks the last s_tick of a bit period.
// Shared between the transmitter and the receiver.
module uart_bit_timer #(
    parameter int OS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic s_tick,
    input  logic clr,
    output logic tc
);
    import uart_pkg::*;

    localparam int SW = (OS > 1) ? $clog2(OS) : 1;

    logic [SW-1:0] s_q;
    logic [SW-1:0] s_d;

    always_comb begin
        s_d = s_q;
        tc  = 1'b0;
        if (clr) begin
            s_d = '0;
        end else if (s_tick) begin
            if (s_q == SW'(OS - 1)) begin
                s_d = '0;
                tc  = 1'b1;
            end else begin
                s_d = s_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= '0;
        end else begin
            s_q <= s_d;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (5..DBIT_MAX data, parity, 1/2 stop).
// Define UART_TX_BREAK_EN to add the brk_req/brk_active break generator.
module uart_tx_cfg #(
    parameter int DBIT_MAX = 8,
    parameter int OS       = 16,
    parameter int BRK_BITS = 13
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_tick,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic [DBIT_MAX-1:0]           tx_data,
    input  logic [$clog2(DBIT_MAX+1)-1:0] cfg_dbits,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
`ifdef UART_TX_BREAK_EN
    input  logic                          brk_req,
    output logic                          brk_active,
`endif
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          tx_done_tick
);
    import uart_pkg::*;

    localparam int DW = $clog2(DBIT_MAX + 1);

    uart_state_e         state_q, state_d;
    logic [DBIT_MAX-1:0] shift_q, shift_d;
    logic [DW-1:0]       n_q, n_d;
    logic [DW-1:0]       dbits_q, dbits_d;
    logic                par_en_q, par_en_d;
    logic                par_bit_q, par_bit_d;
    logic                stop2_q, stop2_d;
    logic                stop_n_q, stop_n_d;
    logic                tx_q, tx_d;

    logic                timer_clr;
    logic                tc;
    logic                hs;
    logic [DW-1:0]       dbits_c;
    logic [DBIT_MAX-1:0] mask;
    logic [DBIT_MAX-1:0] data_m;

`ifdef UART_TX_BREAK_EN
    localparam int BW = $clog2(BRK_BITS + 1);
    logic [BW-1:0] brk_n_q, brk_n_d;
    logic          brk_done;
`endif

    uart_bit_timer #(
        .OS(OS)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .s_tick(s_tick),
        .clr   (timer_clr),
        .tc    (tc)
    );

    always_comb begin
        dbits_c = DW'(clamp_dbits(32'(cfg_dbits), DBIT_MAX));
        mask    = '0;
        for (int i = 0; i < DBIT_MAX; i++) begin
            mask[i] = (i < int'(dbits_c));
        end
        data_m = tx_data & mask;
    end

`ifdef UART_TX_BREAK_EN
    assign tx_ready   = (state_q == IDLE) && !brk_req;
    assign brk_active = (state_q == BREAK);
    assign brk_done   = (brk_n_q == BW'(BRK_BITS)) ||
                        (tc && brk_n_q == BW'(BRK_BITS - 1));
`else
    assign tx_ready = (state_q == IDLE);
`endif

    assign hs      = tx_valid && tx_ready;
    assign tx_busy = (state_q != IDLE);
    assign tx      = tx_q;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        n_d          = n_q;
        dbits_d      = dbits_q;
        par_en_d     = par_en_q;
        par_bit_d    = par_bit_q;
        stop2_d      = stop2_q;
        stop_n_d     = stop_n_q;
        timer_clr    = 1'b0;
        tx_done_tick = 1'b0;
`ifdef UART_TX_BREAK_EN
        brk_n_d      = brk_n_q;
`endif
        unique case (state_q)
            IDLE: begin
                // Holding the timer clear here drops any tick coincident with the handshake.
                timer_clr = 1'b1;
`ifdef UART_TX_BREAK_EN
                if (brk_req) begin
                    state_d = BREAK;
                    brk_n_d = '0;
                end else
`endif
                if (hs) begin
                    state_d   = START;
                    shift_d   = data_m;
                    dbits_d   = dbits_c;
                    par_en_d  = (cfg_parity == PAR_EVEN) ||
                                (cfg_parity == PAR_ODD);
                    par_bit_d = (cfg_parity == PAR_ODD) ? ~^data_m : ^data_m;
                    stop2_d   = cfg_stop2;
                    stop_n_d  = 1'b0;
                    n_d       = '0;
                end
            end
            START: begin
                if (tc) begin
                    state_d = DATA;
                    n_d     = '0;
                end
            end
            DATA: begin
                if (tc) begin
                    shift_d = shift_q >> 1;
                    if (n_q == dbits_q - 1'b1) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        n_d = n_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tc) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tc) begin
                    if (stop2_q && !stop_n_q) begin
                        stop_n_d = 1'b1;
                    end else begin
                        state_d      = IDLE;
                        tx_done_tick = 1'b1;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            BREAK: begin
                if (tc && brk_n_q != BW'(BRK_BITS)) begin
                    brk_n_d = brk_n_q + 1'b1;
                end
                if (brk_done && !brk_req) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level follows the next state so tx drops one clock after the handshake.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_bit_q;
            STOP:    tx_d = 1'b1;
`ifdef UART_TX_BREAK_EN
            BREAK:   tx_d = 1'b0;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            n_q       <= '0;
            dbits_q   <= DW'(DBIT_MAX);
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            stop_n_q  <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            n_q       <= n_d;
            dbits_q   <= dbits_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            stop_n_q  <= stop_n_d;
            tx_q      <= tx_d;
        end
    end

`ifdef UART_TX_BREAK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            brk_n_q <= '0;
        end else begin
            brk_n_q <= brk_n_d;
        end
    end
`endif

endmodule
